// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, mid-bit sampling, parity/stop checks, one-entry valid/ready output.
// Build option: define UART_RX_MAJORITY_EN for a 2-of-3 majority vote around each sample point.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 data_tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 active_flag
);
  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
  localparam logic           ODD       = (PARITY_ODD != 0);
  localparam logic           HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 frame_done;

  logic [1:0]           sync_q;
  logic                 rx_s, rx_p_q;
  logic [1:0]           fill_q;
  logic                 sbit, strobe, start_edge;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, parity_err_q, frame_err_q, overrun_q;

  // fill_q saturates once rx_p holds a real line value, so a line low out of reset never looks like an edge
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      rx_p_q <= 1'b1;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[0], data_tx};
      rx_p_q <= sync_q[1];
      if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
    end
  end

  assign rx_s       = sync_q[1];
  assign start_edge = (fill_q == 2'd3) && rx_p_q && !rx_s;

`ifdef UART_RX_MAJORITY_EN
  // Vote is taken one cycle after the nominal point, once the +1 value exists
  localparam logic [CW-1:0] SAMPLE_AT = CW'(OVERSAMPLE / 2);
  logic rx_pp_q;
  always_ff @(posedge baud_clk) begin
    if (reset) rx_pp_q <= 1'b1;
    else       rx_pp_q <= rx_p_q;
  end
  assign sbit = (rx_s & rx_p_q) | (rx_s & rx_pp_q) | (rx_p_q & rx_pp_q);
`else
  localparam logic [CW-1:0] SAMPLE_AT = CW'(OVERSAMPLE / 2 - 1);
  assign sbit = rx_s;
`endif

  assign strobe = (cnt_q == SAMPLE_AT);

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    if (state_q != S_IDLE) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (strobe) state_d = sbit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (strobe) begin
          shift_d = {sbit, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BCW'(1);
          end
        end
      end
      S_PARITY: begin
        if (strobe) begin
          perr_d  = sbit ^ (^shift_q) ^ ODD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (strobe) begin
          if (!sbit) ferr_d = 1'b1;
          if (bit_q == LAST_STOP) begin
            state_d    = S_IDLE;
            frame_done = 1'b1;
          end else begin
            bit_d = bit_q + BCW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A frame landing while the register is held and not being read is dropped
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= frame_done && rx_valid_q && !rx_ready;
      if (frame_done && (!rx_valid_q || rx_ready)) begin
        rx_data_q    <= shift_q;
        parity_err_q <= perr_q;
        frame_err_q  <= ferr_d;
        rx_valid_q   <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign active_flag = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: latency, parity, framing, false start, overrun, reset mid-frame, glitch, back-to-back.
module tb_uart_rx_os;
  localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, data_tx, rx_ready, ready_odd;
  logic [7:0] rx_data, odd_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, active_flag;
  logic       odd_valid, odd_perr, odd_ferr, odd_ovr, odd_act;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  uart_rx_os #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .OVERSAMPLE(OS)) dut (
    .baud_clk(clk), .reset(reset), .data_tx(data_tx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
    .active_flag(active_flag));

  uart_rx_os #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .OVERSAMPLE(OS)) u_odd (
    .baud_clk(clk), .reset(reset), .data_tx(data_tx), .rx_data(odd_data), .rx_valid(odd_valid),
    .rx_ready(ready_odd), .parity_err(odd_perr), .frame_err(odd_ferr), .overrun_err(odd_ovr),
    .active_flag(odd_act));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records transfers and edge times on the falling clock edge
  logic [7:0] got_d[$];
  logic       got_pe[$], got_fe[$];
  int         rise_cyc = -1, af_rise = -1, af_fall = -1, af_rise_n = 0, ovr_cnt = 0;
  logic       vld_prev = 1'b0, af_prev = 1'b0;
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      got_d.push_back(rx_data);
      got_pe.push_back(parity_err);
      got_fe.push_back(frame_err);
    end
    if (rx_valid && !vld_prev) rise_cyc = cyc;
    if (active_flag && !af_prev) begin af_rise = cyc; af_rise_n++; end
    if (!active_flag && af_prev) af_fall = cyc;
    if (overrun_err) ovr_cnt++;
    vld_prev = rx_valid;
    af_prev  = active_flag;
  end

  // Drives start, 8 data (LSB first), parity, stop; one bit per OS cycles. t0 = cycle the edge reaches rx_s.
  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                            input int glitch_at, input int ncyc, output int t0);
    logic [10:0] bits;
    bits = {sb, pb, d, 1'b0};
    t0 = cyc + 2;
    for (int c = 0; c < ncyc; c++) begin
      data_tx = bits[c/OS] ^ (c == glitch_at);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    data_tx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n0;
    reset = 1'b1; data_tx = 1'b0; rx_ready = 1'b1; ready_odd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_checks++; if ({parity_err, frame_err, overrun_err} !== 3'b000) begin n_fail++; $display("FAIL reset_errs: got %b want 000", {parity_err, frame_err, overrun_err}); end
    n_checks++; if (active_flag !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active_flag); end
    n0 = af_rise_n;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++; if (af_rise_n !== n0) begin n_fail++; $display("FAIL low_after_reset_start: got %0d starts want 0", af_rise_n - n0); end
    idle(10);
  endtask

  task automatic test_basic();
    int t0, n0;
    n0 = got_d.size();
    send_frame(8'hA5, 1'b0, 1'b1, -1, 176, t0);
    idle(8);
    n_checks++; if (got_d.size() !== n0 + 1) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", got_d.size(), n0 + 1); end
    n_checks++; if (got_d[n0] !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", got_d[n0]); end
    n_checks++; if ({got_pe[n0], got_fe[n0]} !== 2'b00) begin n_fail++; $display("FAIL basic_errs: got %b want 00", {got_pe[n0], got_fe[n0]}); end
    n_checks++; if (rise_cyc !== t0 + 169 + DLY) begin n_fail++; $display("FAIL basic_latency: got T0+%0d want T0+%0d", rise_cyc - t0, 169 + DLY); end
    n_checks++; if (af_rise !== t0 + 1) begin n_fail++; $display("FAIL basic_active_rise: got T0+%0d want T0+1", af_rise - t0); end
    n_checks++; if (af_fall !== t0 + 169 + DLY) begin n_fail++; $display("FAIL basic_active_fall: got T0+%0d want T0+%0d", af_fall - t0, 169 + DLY); end
  endtask

  task automatic test_parity();
    int t0, n0;
    n0 = got_d.size();
    ready_odd = 1'b0;
    send_frame(8'h01, 1'b0, 1'b1, -1, 176, t0);
    idle(8);
    n_checks++; if (got_d[n0] !== 8'h01) begin n_fail++; $display("FAIL parity_data: got %h want 01", got_d[n0]); end
    n_checks++; if (got_pe[n0] !== 1'b1) begin n_fail++; $display("FAIL parity_even_err: got %b want 1", got_pe[n0]); end
    n_checks++; if ({odd_valid, odd_data} !== {1'b1, 8'h01}) begin n_fail++; $display("FAIL parity_odd_word: got %b/%h want 1/01", odd_valid, odd_data); end
    n_checks++; if ({odd_perr, odd_ferr, odd_ovr, odd_act} !== 4'b0000) begin n_fail++; $display("FAIL parity_odd_flags: got %b want 0000", {odd_perr, odd_ferr, odd_ovr, odd_act}); end
    ready_odd = 1'b1;
    idle(2);
  endtask

  task automatic test_frame_err();
    int t0, n0;
    n0 = got_d.size();
    send_frame(8'h55, 1'b0, 1'b0, -1, 176, t0);
    data_tx = 1'b0;
    repeat (20 * OS) @(posedge clk);
    #1;
    n_checks++; if (got_d.size() !== n0 + 1) begin n_fail++; $display("FAIL ferr_count: got %0d want %0d", got_d.size(), n0 + 1); end
    n_checks++; if ({got_d[n0], got_pe[n0], got_fe[n0]} !== {8'h55, 1'b0, 1'b1}) begin n_fail++; $display("FAIL ferr_word: got %h/%b/%b want 55/0/1", got_d[n0], got_pe[n0], got_fe[n0]); end
    n_checks++; if (active_flag !== 1'b0) begin n_fail++; $display("FAIL ferr_low_active: got %b want 0", active_flag); end
    idle(40);
    n_checks++; if (got_d.size() !== n0 + 1) begin n_fail++; $display("FAIL ferr_rise_only: got %0d want %0d", got_d.size(), n0 + 1); end
    send_frame(8'h3C, 1'b0, 1'b1, -1, 176, t0);
    idle(8);
    n_checks++; if (got_d.size() !== n0 + 2 || got_d[n0+1] !== 8'h3C || got_fe[n0+1] !== 1'b0) begin n_fail++; $display("FAIL ferr_recover: got n=%0d %h want n=%0d 3c", got_d.size(), got_d[n0+1], n0 + 2); end
  endtask

  task automatic test_false_start();
    int t0, n0;
    n0 = got_d.size();
    t0 = cyc + 2;
    data_tx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(40);
    n_checks++; if (af_rise !== t0 + 1) begin n_fail++; $display("FAIL false_rise: got T0+%0d want T0+1", af_rise - t0); end
    n_checks++; if (af_fall !== t0 + 9 + DLY) begin n_fail++; $display("FAIL false_fall: got T0+%0d want T0+%0d", af_fall - t0, 9 + DLY); end
    n_checks++; if (got_d.size() !== n0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL false_no_word: got n=%0d valid=%b want n=%0d valid=0", got_d.size(), rx_valid, n0); end
  endtask

  task automatic test_overrun();
    int t0, n0, o0;
    n0 = got_d.size();
    o0 = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, -1, 176, t0);
    idle(8);
    n_checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL ovr_first_held: got %b/%h want 1/11", rx_valid, rx_data); end
    n_checks++; if (ovr_cnt !== o0) begin n_fail++; $display("FAIL ovr_early: got %0d pulses want 0", ovr_cnt - o0); end
    send_frame(8'h3C, 1'b0, 1'b1, -1, 176, t0);
    idle(8);
    n_checks++; if (ovr_cnt !== o0 + 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d pulses want 1", ovr_cnt - o0); end
    n_checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL ovr_still_held: got %b/%h want 1/11", rx_valid, rx_data); end
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (got_d.size() !== n0 + 1 || got_d[n0] !== 8'h11) begin n_fail++; $display("FAIL ovr_accept: got n=%0d %h want n=%0d 11", got_d.size(), got_d[n0], n0 + 1); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_drop: got %b want 0", rx_valid); end
    idle(40);
    n_checks++; if (got_d.size() !== n0 + 1) begin n_fail++; $display("FAIL ovr_no_3c: got n=%0d want %0d", got_d.size(), n0 + 1); end
  endtask

  task automatic test_reset_mid();
    int t0, n0;
    rx_ready = 1'b0;
    send_frame(8'h22, 1'b0, 1'b1, -1, 176, t0);
    idle(8);
    n_checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL rstmid_pre_held: got %b/%h want 1/22", rx_valid, rx_data); end
    send_frame(8'h7E, 1'b0, 1'b1, -1, 70, t0);
    n_checks++; if (active_flag !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_frame: got %b want 1", active_flag); end
    reset = 1'b1;
    data_tx = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if ({rx_valid, rx_data, parity_err, frame_err, overrun_err, active_flag} !== 13'd0) begin n_fail++; $display("FAIL rstmid_outputs: got %b/%h/%b%b%b%b want all zero", rx_valid, rx_data, parity_err, frame_err, overrun_err, active_flag); end
    reset = 1'b0;
    rx_ready = 1'b1;
    idle(8);
    n0 = got_d.size();
    send_frame(8'h7E, 1'b0, 1'b1, -1, 176, t0);
    idle(8);
    n_checks++; if (got_d.size() !== n0 + 1 || {got_d[n0], got_pe[n0], got_fe[n0]} !== {8'h7E, 2'b00}) begin n_fail++; $display("FAIL rstmid_next_frame: got n=%0d %h/%b%b want n=%0d 7e/00", got_d.size(), got_d[n0], got_pe[n0], got_fe[n0], n0 + 1); end
  endtask

  task automatic test_glitch();
    int t0, n0;
    logic [7:0] exp_d;
    logic       exp_pe;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 8'h5A; exp_pe = 1'b0;
`else
    exp_d = 8'h5E; exp_pe = 1'b1;
`endif
    n0 = got_d.size();
    send_frame(8'h5A, 1'b0, 1'b1, 56, 176, t0);
    idle(8);
    n_checks++; if (got_d[n0] !== exp_d || got_pe[n0] !== exp_pe) begin n_fail++; $display("FAIL glitch_word: got %h/%b want %h/%b", got_d[n0], got_pe[n0], exp_d, exp_pe); end
  endtask

  task automatic test_back_to_back();
    int t0, n0;
    logic [7:0] exp_w [3];
    exp_w[0] = 8'h00; exp_w[1] = 8'hFF; exp_w[2] = 8'h81;
    n0 = got_d.size();
    for (int i = 0; i < 3; i++) send_frame(exp_w[i], 1'b0, 1'b1, -1, 176, t0);
    idle(20);
    n_checks++; if (got_d.size() !== n0 + 3) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_d.size() - n0, 3); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({got_d[n0+i], got_pe[n0+i], got_fe[n0+i]} !== {exp_w[i], 2'b00}) begin n_fail++; $display("FAIL b2b_word%0d: got %h/%b%b want %h/00", i, got_d[n0+i], got_pe[n0+i], got_fe[n0+i], exp_w[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_false_start();
    test_overrun();
    test_reset_mid();
    test_glitch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
